// File: rtl/rtc_hms_if.sv
// Control/status bundle between the time-of-day counter and its display/alarm users.
interface rtc_hms_if;
  logic       run;
  logic       mode_12h;
  logic       load_vld;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hr;
  logic       alarm_en;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hr;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       pm;
  logic       sec_tick;
  logic       min_wrap;
  logic       hr_wrap;
  logic       day_wrap;
  logic       load_err;
  logic       alarm_hit;

  modport master (
    output run, mode_12h, load_vld, load_sec, load_min, load_hr,
           alarm_en, alarm_min, alarm_hr,
    input  sec, min, hr, pm, sec_tick, min_wrap, hr_wrap, day_wrap,
           load_err, alarm_hit
  );

  modport slave (
    input  run, mode_12h, load_vld, load_sec, load_min, load_hr,
           alarm_en, alarm_min, alarm_hr,
    output sec, min, hr, pm, sec_tick, min_wrap, hr_wrap, day_wrap,
           load_err, alarm_hit
  );
endinterface

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter: prescaler to a 1 Hz advance, h:m:s cascade, checked load,
// 12/24h display mapping and an hour:minute alarm.
module rtc_hms_counter #(
  parameter int TICK_DIV = 100,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59
) (
  input logic      clk,
  input logic      rst,
  rtc_hms_if.slave bus
);
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
  localparam logic [5:0]     S_LAST   = 6'(SEC_MAX);
  localparam logic [5:0]     M_LAST   = 6'(MIN_MAX);
  localparam logic [4:0]     H_LAST   = 5'd23;

  logic [PW-1:0] r_pre;
  logic [5:0]    r_sec, r_min;
  logic [4:0]    r_hr24;
  logic          r_sec_tick, r_min_wrap, r_hr_wrap, r_day_wrap, r_load_err, r_alarm_hit;

  logic          w_adv, w_s_wrap, w_m_wrap, w_d_wrap, w_load_ok, w_alarm;
  logic [5:0]    w_sec_nx, w_min_nx;
  logic [4:0]    w_hr_nx, w_hr_disp;

  assign w_adv    = bus.run && (r_pre == PRE_LAST);
  assign w_s_wrap = (r_sec == S_LAST);
  assign w_m_wrap = w_s_wrap && (r_min == M_LAST);
  assign w_d_wrap = w_m_wrap && (r_hr24 == H_LAST);

  assign w_sec_nx = w_s_wrap ? 6'd0 : r_sec + 6'd1;
  assign w_min_nx = w_m_wrap ? 6'd0 : (w_s_wrap ? r_min + 6'd1 : r_min);
  assign w_hr_nx  = w_d_wrap ? 5'd0 : (w_m_wrap ? r_hr24 + 5'd1 : r_hr24);

  assign w_load_ok = (bus.load_sec <= S_LAST) && (bus.load_min <= M_LAST) &&
                     (bus.load_hr <= H_LAST);

  // State never leaves range, so out-of-range alarm settings can never match.
  assign w_alarm = bus.alarm_en && w_s_wrap && (w_min_nx == bus.alarm_min) &&
                   (w_hr_nx == bus.alarm_hr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hr24      <= '0;
      r_sec_tick  <= 1'b0;
      r_min_wrap  <= 1'b0;
      r_hr_wrap   <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_load_err  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else begin
      r_sec_tick  <= 1'b0;
      r_min_wrap  <= 1'b0;
      r_hr_wrap   <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_load_err  <= 1'b0;
      r_alarm_hit <= 1'b0;
      if (bus.load_vld && w_load_ok) begin
        // Accepted load wins over a coincident advance and restarts the second.
        r_pre  <= '0;
        r_sec  <= bus.load_sec;
        r_min  <= bus.load_min;
        r_hr24 <= bus.load_hr;
      end else begin
        r_load_err <= bus.load_vld;
        if (bus.run)
          r_pre <= w_adv ? '0 : r_pre + PRE_ONE;
        if (w_adv) begin
          r_sec       <= w_sec_nx;
          r_min       <= w_min_nx;
          r_hr24      <= w_hr_nx;
          r_sec_tick  <= 1'b1;
          r_min_wrap  <= w_s_wrap;
          r_hr_wrap   <= w_m_wrap;
          r_day_wrap  <= w_d_wrap;
          r_alarm_hit <= w_alarm;
        end
      end
    end
  end

  always_comb begin
    w_hr_disp = r_hr24;
    if (bus.mode_12h) begin
      if (r_hr24 == 5'd0)      w_hr_disp = 5'd12;
      else if (r_hr24 > 5'd12) w_hr_disp = r_hr24 - 5'd12;
    end
  end

  assign bus.sec       = r_sec;
  assign bus.min       = r_min;
  assign bus.hr        = w_hr_disp;
  assign bus.pm        = (r_hr24 >= 5'd12);
  assign bus.sec_tick  = r_sec_tick;
  assign bus.min_wrap  = r_min_wrap;
  assign bus.hr_wrap   = r_hr_wrap;
  assign bus.day_wrap  = r_day_wrap;
  assign bus.load_err  = r_load_err;
  assign bus.alarm_hit = r_alarm_hit;
endmodule

// File: tb/tb_rtc_hms_counter.sv
// Scoreboard bench: stimulus queues the expected pulse events (cycle, time, pulse set);
// a negedge monitor pops one entry per observed pulse cycle.
module tb_rtc_hms_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtc_hms_if ifc();

  rtc_hms_counter #(.TICK_DIV(TD), .SEC_MAX(59), .MIN_MAX(59)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  typedef struct {
    int         cyc;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       pm;
    logic [5:0] p;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [5:0] pv;
  assign pv = {ifc.sec_tick, ifc.min_wrap, ifc.hr_wrap, ifc.day_wrap, ifc.load_err, ifc.alarm_hit};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int s, input int m, input int h, input logic pm,
                      input logic [5:0] p);
    exp_t e;
    e.cyc = c; e.s = 6'(s); e.m = 6'(m); e.h = 5'(h); e.pm = pm; e.p = p;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_load(input int s, input int m, input int h);
    ifc.load_sec = 6'(s);
    ifc.load_min = 6'(m);
    ifc.load_hr  = 5'(h);
    ifc.load_vld = 1'b1;
  endtask

  // Monitor: every cycle with any pulse must match the next queued event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pv != 6'b0) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc=%0d pulses=%b time=%0d:%0d:%0d, expected no pulse",
                 cyc, pv, ifc.hr, ifc.min, ifc.sec);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.s != ifc.sec || e.m != ifc.min || e.h != ifc.hr ||
            e.pm != ifc.pm || e.p != pv) begin
          n_fail++;
          $display("FAIL sb_event: got cyc=%0d %0d:%0d:%0d pm=%b p=%b, expected cyc=%0d %0d:%0d:%0d pm=%b p=%b",
                   cyc, ifc.hr, ifc.min, ifc.sec, ifc.pm, pv, e.cyc, e.h, e.m, e.s, e.pm, e.p);
        end
      end
    end
  end

  initial begin
    int c;
    ifc.run = 1'b0; ifc.mode_12h = 1'b0; ifc.load_vld = 1'b0;
    ifc.load_sec = '0; ifc.load_min = '0; ifc.load_hr = '0;
    ifc.alarm_en = 1'b0; ifc.alarm_min = '0; ifc.alarm_hr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sec", ifc.sec, 0);
    chk("rst_min", ifc.min, 0);
    chk("rst_hr24", ifc.hr, 0);
    chk("rst_pm", ifc.pm, 0);
    chk("rst_pulses", pv, 0);
    ifc.mode_12h = 1'b1; #1;
    chk("rst_hr12", ifc.hr, 12);
    ifc.mode_12h = 1'b0;

    // Free run from reset release: 60 ticks, one per 4 cycles
    @(negedge clk); c = cyc;
    for (int i = 1; i <= 60; i++)
      push(c + TD*i, i % 60, i / 60, 0, 1'b0, (i == 60) ? 6'b110000 : 6'b100000);
    rst = 1'b0; ifc.run = 1'b1;
    repeat (240) @(negedge clk);

    // Day wrap from 23:59:58
    c = cyc; set_load(58, 59, 23);
    push(c + 5, 59, 59, 23, 1'b1, 6'b100000);
    push(c + 9, 0, 0, 0, 1'b0, 6'b111100);
    @(negedge clk); ifc.load_vld = 1'b0;
    repeat (8) @(negedge clk);

    // Rejected load, then 13:05:00 and display mapping
    ifc.run = 1'b0; c = cyc; set_load(60, 0, 0);
    push(c + 1, 0, 0, 0, 1'b0, 6'b000010);
    @(negedge clk); set_load(0, 5, 13);
    @(negedge clk); ifc.load_vld = 1'b0;
    chk("ld_sec", ifc.sec, 0);
    chk("ld_min", ifc.min, 5);
    ifc.mode_12h = 1'b1; #1;
    chk("hr12_13", ifc.hr, 1);
    chk("pm_13", ifc.pm, 1);
    ifc.mode_12h = 1'b0; #1;
    chk("hr24_13", ifc.hr, 13);

    // Load on the same edge as an advance, then hold and resume
    c = cyc; ifc.run = 1'b1;
    repeat (3) @(negedge clk);
    set_load(30, 20, 10);
    push(c + 8, 31, 20, 10, 1'b0, 6'b100000);
    @(negedge clk); ifc.load_vld = 1'b0;
    chk("ldadv_sec", ifc.sec, 30);
    chk("ldadv_min", ifc.min, 20);
    chk("ldadv_hr", ifc.hr, 10);
    repeat (4) @(negedge clk);
    ifc.run = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_sec", ifc.sec, 31);
    chk("hold_min", ifc.min, 20);
    chk("hold_hr", ifc.hr, 10);
    c = cyc; ifc.run = 1'b1;
    push(c + 4, 32, 20, 10, 1'b0, 6'b100000);
    repeat (4) @(negedge clk);

    // Alarm 07:30: hit by advance, not by direct load
    c = cyc; ifc.alarm_en = 1'b1; ifc.alarm_hr = 5'd7; ifc.alarm_min = 6'd30;
    set_load(59, 29, 7);
    push(c + 5, 0, 30, 7, 1'b0, 6'b110001);
    @(negedge clk); ifc.load_vld = 1'b0;
    repeat (4) @(negedge clk);
    set_load(0, 30, 7);
    push(c + 10, 1, 30, 7, 1'b0, 6'b100000);
    @(negedge clk); ifc.load_vld = 1'b0;
    repeat (4) @(negedge clk);
    ifc.alarm_en = 1'b0;

    // Async reset mid-count at 12:34:56
    c = cyc; set_load(56, 34, 12);
    @(negedge clk); ifc.load_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_hr", ifc.hr, 12);
    chk("pre_rst_pm", ifc.pm, 1);
    #2 rst = 1'b1; #1;
    chk("mrst_sec", ifc.sec, 0);
    chk("mrst_min", ifc.min, 0);
    chk("mrst_hr24", ifc.hr, 0);
    chk("mrst_pm", ifc.pm, 0);
    ifc.mode_12h = 1'b1; #1;
    chk("mrst_hr12", ifc.hr, 12);
    ifc.mode_12h = 1'b0;
    @(negedge clk); @(negedge clk);
    c = cyc; rst = 1'b0;
    push(c + 4, 1, 0, 0, 1'b0, 6'b100000);
    repeat (4) @(negedge clk);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_hms_counter.md
Name: rtc_hms_counter

Overview:
- Parametrised time-of-day counter. Successor to the fixed seconds/minutes/hours counter.
- Adds an internal prescaler from the system clock to a 1 Hz tick, a run/hold control, synchronous time load with range checking, a 12/24-hour display mode, carry/wrap pulses and an hour:minute alarm.
- Sits between the system clock domain and display/alarm logic. All logic is in one clock domain.

Parameters:
- TICK_DIV, 100, clk cycles per second tick; legal range 1..2^24, never 0. Prescaler width is $clog2(TICK_DIV), minimum 1.
- SEC_MAX, 59, last seconds value before wrap; range 1..63.
- MIN_MAX, 59, last minutes value before wrap; range 1..63.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = prescaler and time advance; 0 = hold all counters.
- mode_12h  in  1  0 = 24-hour display; 1 = 12-hour display. Affects outputs only.
- load_vld  in  1  single-cycle request to load a time.
- load_sec  in  6  seconds to load.
- load_min  in  6  minutes to load.
- load_hr  in  5  hours to load, always 24-hour format (0..23).
- alarm_en  in  1  alarm enable.
- alarm_min  in  6  alarm minute.
- alarm_hr  in  5  alarm hour, 24-hour format.
- sec  out  6  current seconds.
- min  out  6  current minutes.
- hr  out  5  current hour in display format.
- pm  out  1  1 when internal hour is 12..23; valid in both modes.
- sec_tick  out  1  1-cycle pulse on each time advance.
- min_wrap  out  1  1-cycle pulse when seconds wrap SEC_MAX->0.
- hr_wrap  out  1  1-cycle pulse when minutes wrap MIN_MAX->0.
- day_wrap  out  1  1-cycle pulse when hours wrap 23->0.
- load_err  out  1  1-cycle pulse when a load is rejected.
- alarm_hit  out  1  1-cycle pulse on alarm match.

Behaviour:
- Reset (async assert, sync-to-clk deassert by caller): prescaler = 0, sec = 0, min = 0, internal hr24 = 0. All pulse outputs are 0. Displayed hr is 0 in 24h mode and 12 in 12h mode; pm = 0.
- Prescaler counts 0..TICK_DIV-1 while run = 1 and wraps to 0.
  - An advance occurs on the clk edge where run = 1 and prescaler == TICK_DIV-1.
  - TICK_DIV = 1 gives an advance every cycle while run = 1.
- Advance: sec increments.
  - If sec == SEC_MAX: sec -> 0, min increments.
  - If min == MIN_MAX: min -> 0, hr24 increments.
  - If hr24 == 23: hr24 -> 0.
- Pulse outputs are registered. sec_tick, min_wrap, hr_wrap and day_wrap are high for exactly the cycle in which the new values are first visible.
- Carries cascade in the same edge, so 23:59:59 -> 00:00:00 asserts all four pulses together.
- run = 0 freezes prescaler, sec, min and hr24. No pulses occur while held. Resuming continues from the frozen prescaler value.
- Load (load_vld = 1 at an edge):
  - Accepted if load_sec <= SEC_MAX, load_min <= MIN_MAX and load_hr <= 23. Fields take effect at that edge, the prescaler clears to 0, and no pulses are generated.
  - If any field is out of range, all state is unchanged (the prescaler advances normally) and load_err pulses for 1 cycle.
- Load has priority over a coincident advance: the advance is discarded, and the next advance occurs TICK_DIV run-cycles after the load. Load is honoured regardless of run.
- Display mapping is combinational from hr24 and mode_12h.
  - 24h mode: hr = hr24.
  - 12h mode: hr24 0 -> 12; 1..12 -> same value; 13..23 -> hr24-12.
  - pm = (hr24 >= 12).
  - Toggling mode_12h never alters state.
- Alarm: alarm_hit pulses 1 cycle, coincident with sec_tick, when an advance produces sec == 0, min == alarm_min and hr24 == alarm_hr, with alarm_en = 1 at that edge.
  - A load never triggers alarm_hit, even if it lands exactly on the alarm time.
  - alarm_hr > 23 or alarm_min > MIN_MAX never matches.
- Mid-operation reset clears everything immediately, including any in-flight pulse.
- All arithmetic is unsigned. Comparisons are zero-extended to the field width.

Test Plan:
- TICK_DIV=4: deassert rst, run=1 -> first sec_tick 4 cycles after reset release, sec = 1; after 60 ticks sec = 0, min = 1, with min_wrap coincident with sec_tick.
- Load 23:59:58, run=1 -> after 2 ticks time reads 00:00:00; sec_tick, min_wrap, hr_wrap and day_wrap all pulse on the same cycle; pm goes 1 -> 0.
- Load sec=60 (others valid) -> load_err pulses 1 cycle, time unchanged; then load 13:05:00 with mode_12h=1 -> hr = 1, pm = 1; set mode_12h=0 -> hr = 13.
- Load asserted on the same edge as an advance -> loaded value shown with no sec_tick; the next sec_tick comes exactly 4 cycles later. run=0 for 10 cycles -> no change and no pulses.
- alarm_en=1, alarm 07:30; load 07:29:59 -> the next tick gives 07:30:00 with alarm_hit high for 1 cycle. Load 07:30:00 directly -> no alarm_hit.
- Assert rst mid-count at 12:34:56 -> outputs go 0/12 asynchronously; after release, counting restarts from 00:00:00 with the prescaler at 0.
